// File: rtl/stopwatch_display_if.sv
// Port bundle between the stopwatch core side and the display back-end.
// The master drives time and state; the display (slave) drives scan and BCD outputs.
interface stopwatch_display_if;
    logic [7:0]  minute;
    logic [5:0]  seconds;
    logic [1:0]  state;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] bcd;
    logic        busy;

    modport master (
        output minute, seconds, state,
        input  an, seg, dp, bcd, busy
    );

    modport slave (
        input  minute, seconds, state,
        output an, seg, dp, bcd, busy
    );
endinterface

// File: rtl/stopwatch_display.sv
// MM:SS display back-end: sequential double-dabble BCD conversion of a clamped
// time snapshot, a 4-digit common-anode scan, and a state-dependent colon.
module stopwatch_display #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned BLINK_DIV   = 500000
) (
    input  logic               clk,
    input  logic               reset,
    stopwatch_display_if.slave bus
);
    localparam int unsigned RefW = $clog2(REFRESH_DIV);
    localparam int unsigned BlkW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {ConvIdle, ConvShift, ConvDone} conv_e;

    conv_e            conv_q, conv_d;
    logic [2:0]       iter_q, iter_d;
    logic [14:0]      min_sr_q, min_sr_d, sec_sr_q, sec_sr_d;
    logic [6:0]       cap_min_q, cap_min_d, cap_sec_q, cap_sec_d;
    logic [6:0]       last_min_q, last_min_d, last_sec_q, last_sec_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic [RefW-1:0]  ref_q, ref_d;
    logic [1:0]       idx_q, idx_d;
    logic             scan_on_q, scan_on_d;
    logic [BlkW-1:0]  blink_q, blink_d;
    logic             phase_q, phase_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [6:0]       min_clamp, sec_clamp;
    logic [3:0]       nibble;

    // One add-3-then-shift step over {tens, ones, binary}.
    function automatic logic [14:0] dabble(input logic [14:0] sr);
        logic [3:0] t;
        logic [3:0] o;
        t = sr[14:11];
        o = sr[10:7];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t, o, sr[6:0]} << 1;
    endfunction

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        min_clamp = (bus.minute > 8'd99) ? 7'd99 : bus.minute[6:0];
        sec_clamp = (bus.seconds > 6'd59) ? 7'd59 : {1'b0, bus.seconds};

        conv_d     = conv_q;
        iter_d     = iter_q;
        min_sr_d   = min_sr_q;
        sec_sr_d   = sec_sr_q;
        cap_min_d  = cap_min_q;
        cap_sec_d  = cap_sec_q;
        last_min_d = last_min_q;
        last_sec_d = last_sec_q;
        bcd_d      = bcd_q;
        busy_d     = busy_q;

        case (conv_q)
            ConvIdle: begin
                if ({min_clamp, sec_clamp} != {last_min_q, last_sec_q}) begin
                    cap_min_d = min_clamp;
                    cap_sec_d = sec_clamp;
                    min_sr_d  = {8'd0, min_clamp};
                    sec_sr_d  = {8'd0, sec_clamp};
                    iter_d    = 3'd0;
                    busy_d    = 1'b1;
                    conv_d    = ConvShift;
                end
            end
            ConvShift: begin
                min_sr_d = dabble(min_sr_q);
                sec_sr_d = dabble(sec_sr_q);
                iter_d   = iter_q + 3'd1;
                if (iter_q == 3'd6) conv_d = ConvDone;
            end
            ConvDone: begin
                bcd_d      = {min_sr_q[14:7], sec_sr_q[14:7]};
                last_min_d = cap_min_q;
                last_sec_d = cap_sec_q;
                busy_d     = 1'b0;
                conv_d     = ConvIdle;
            end
            default: conv_d = ConvIdle;
        endcase

        // The first edge out of reset only switches the scan on, so digit 0 gets a full slot.
        scan_on_d = 1'b1;
        ref_d     = ref_q;
        idx_d     = idx_q;
        if (scan_on_q) begin
            if (ref_q == RefW'(REFRESH_DIV - 1)) begin
                ref_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                ref_d = ref_q + 1'b1;
            end
        end

        blink_d = '0;
        phase_d = 1'b0;
        if (bus.state == 2'b10) begin
            if (blink_q == BlkW'(BLINK_DIV - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
                phase_d = phase_q;
            end
        end

        // Outputs are built from next-state values so they move with the index and new bcd.
        an_d   = ~(4'b0001 << idx_d);
        nibble = bcd_d[{idx_d, 2'b00} +: 4];
        seg_d  = seg_lut(nibble);
        dp_d   = 1'b1;
        if (idx_d == 2'd2) begin
            case (bus.state)
                2'b01:   dp_d = 1'b0;
                2'b10:   dp_d = phase_d;
                default: dp_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_q     <= ConvIdle;
            iter_q     <= 3'd0;
            min_sr_q   <= '0;
            sec_sr_q   <= '0;
            cap_min_q  <= '0;
            cap_sec_q  <= '0;
            last_min_q <= '0;
            last_sec_q <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            ref_q      <= '0;
            idx_q      <= 2'd0;
            scan_on_q  <= 1'b0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            conv_q     <= conv_d;
            iter_q     <= iter_d;
            min_sr_q   <= min_sr_d;
            sec_sr_q   <= sec_sr_d;
            cap_min_q  <= cap_min_d;
            cap_sec_q  <= cap_sec_d;
            last_min_q <= last_min_d;
            last_sec_q <= last_sec_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            scan_on_q  <= scan_on_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = dp_q;
    assign bus.bcd  = bcd_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display: reset, scan, conversion, clamp,
// mid-conversion change, colon blink and reset during conversion.
module tb_stopwatch_display;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    stopwatch_display_if ifm ();
    stopwatch_display_if ifb ();

    stopwatch_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm)
    );

    // Short scan period so colon windows land in both blink phases.
    stopwatch_display #(.REFRESH_DIV(2), .BLINK_DIV(8)) u_blink (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [6:0] exp_seg;
        logic       exp_dp;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        ifm.minute  = 8'd0;
        ifm.seconds = 6'd0;
        ifm.state   = 2'b00;
        ifb.minute  = 8'd0;
        ifb.seconds = 6'd0;
        ifb.state   = 2'b00;

        tick(1);
        chk("rst_an", {28'd0, ifm.an}, 32'hF);
        chk("rst_seg", {25'd0, ifm.seg}, 32'h7F);
        chk("rst_dp", {31'd0, ifm.dp}, 32'h1);
        chk("rst_bcd", {16'd0, ifm.bcd}, 32'h0);
        chk("rst_busy", {31'd0, ifm.busy}, 32'h0);
        tick(1);
        reset = 1'b0;

        // Scan at 00:00: four cycles per digit, E D B 7, then back to E.
        for (int c = 0; c < 17; c++) begin
            tick(1);
            case ((c / 4) % 4)
                0:       chk("scan_an", {28'd0, ifm.an}, 32'hE);
                1:       chk("scan_an", {28'd0, ifm.an}, 32'hD);
                2:       chk("scan_an", {28'd0, ifm.an}, 32'hB);
                default: chk("scan_an", {28'd0, ifm.an}, 32'h7);
            endcase
            chk("scan_seg0", {25'd0, ifm.seg}, 32'h40);
            chk("scan_busy", {31'd0, ifm.busy}, 32'h0);
        end

        // 12:34 while RUNNING.
        ifm.state   = 2'b01;
        ifm.minute  = 8'd12;
        ifm.seconds = 6'd34;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("conv_busy_hi", {31'd0, ifm.busy}, 32'h1);
        end
        tick(1);
        chk("conv_busy_lo", {31'd0, ifm.busy}, 32'h0);
        chk("conv_bcd_1234", {16'd0, ifm.bcd}, 32'h1234);
        for (int c = 0; c < 16; c++) begin
            tick(1);
            exp_dp = 1'b1;
            case (ifm.an)
                4'hE:    exp_seg = 7'h19;
                4'hD:    exp_seg = 7'h30;
                4'hB: begin
                    exp_seg = 7'h24;
                    exp_dp  = 1'b0;
                end
                4'h7:    exp_seg = 7'h79;
                default: exp_seg = 7'h7F;
            endcase
            chk("run_an_valid", {31'd0, exp_seg != 7'h7F}, 32'h1);
            chk("run_seg", {25'd0, ifm.seg}, {25'd0, exp_seg});
            chk("run_dp", {31'd0, ifm.dp}, {31'd0, exp_dp});
            chk("idle_no_conv", {31'd0, ifm.busy}, 32'h0);
        end

        // Clamp 200:63 to 99:59.
        ifm.minute  = 8'd200;
        ifm.seconds = 6'd63;
        tick(9);
        chk("clamp_bcd", {16'd0, ifm.bcd}, 32'h9959);
        chk("clamp_busy", {31'd0, ifm.busy}, 32'h0);

        // 05:07 then 05:08 two cycles after capture.
        ifm.minute  = 8'd5;
        ifm.seconds = 6'd7;
        tick(2);
        ifm.seconds = 6'd8;
        tick(7);
        chk("mid_first_bcd", {16'd0, ifm.bcd}, 32'h0507);
        chk("mid_first_busy", {31'd0, ifm.busy}, 32'h0);
        tick(1);
        chk("mid_second_busy", {31'd0, ifm.busy}, 32'h1);
        tick(8);
        chk("mid_second_bcd", {16'd0, ifm.bcd}, 32'h0508);
        chk("mid_second_done", {31'd0, ifm.busy}, 32'h0);

        // Colon on the second instance: PAUSED from idle starts lit.
        ifb.state = 2'b10;
        for (int n = 1; n <= 40; n++) begin
            tick(1);
            exp_dp = (ifb.an == 4'hB) ? ((n / 8) % 2 == 1) : 1'b1;
            chk("blink_dp", {31'd0, ifb.dp}, {31'd0, exp_dp});
        end
        ifb.state = 2'b00;
        for (int n = 0; n < 16; n++) begin
            tick(1);
            chk("idle_dp", {31'd0, ifb.dp}, 32'h1);
        end
        ifb.state = 2'b10;
        tick(5);
        ifb.state = 2'b01;
        for (int n = 0; n < 8; n++) begin
            tick(1);
            exp_dp = (ifb.an == 4'hB) ? 1'b0 : 1'b1;
            chk("running_dp", {31'd0, ifb.dp}, {31'd0, exp_dp});
        end
        ifb.state = 2'b10;
        for (int n = 1; n <= 24; n++) begin
            tick(1);
            exp_dp = (ifb.an == 4'hB) ? ((n / 8) % 2 == 1) : 1'b1;
            chk("reblink_dp", {31'd0, ifb.dp}, {31'd0, exp_dp});
        end

        // Reset during the 59:59 conversion, then a fresh conversion.
        ifm.minute  = 8'd59;
        ifm.seconds = 6'd59;
        tick(5);
        chk("pre_rst_busy", {31'd0, ifm.busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_bcd", {16'd0, ifm.bcd}, 32'h0);
        chk("abort_busy", {31'd0, ifm.busy}, 32'h0);
        chk("abort_an", {28'd0, ifm.an}, 32'hF);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("fresh_busy", {31'd0, ifm.busy}, 32'h1);
        tick(8);
        chk("fresh_bcd", {16'd0, ifm.bcd}, 32'h5959);
        chk("fresh_done", {31'd0, ifm.busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Display back-end for the stopwatch: consumes `minute[7:0]`, `seconds[5:0]` and `state[1:0]` from `stopwatch_top` and drives a 4-digit multiplexed common-anode 7-segment display as MM:SS.
- A sequential double-dabble converter turns a coherent snapshot of the time into BCD.
- A refresh counter scans the four digits.
- The colon (decimal point of the minute-ones digit) reflects the stopwatch state.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles each digit stays enabled (≥2).
- `BLINK_DIV`, default 500000: clock cycles per colon blink half-period in PAUSED (≥2).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `minute`  in  8  minutes from `stopwatch_top`.
- `seconds`  in  6  seconds from `stopwatch_top`.
- `state`  in  2  `stopwatch_top` state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 treated as IDLE.
- `an`  out  4  digit enables, active-low.
  - `an[0]` seconds ones, `an[1]` seconds tens.
  - `an[2]` minute ones, `an[3]` minute tens.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  colon/decimal point, active-low.
- `bcd`  out  16  committed digits `{min_tens, min_ones, sec_tens, sec_ones}`.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Clamp, combinational, ahead of capture:
  - `minute` > 99 becomes 99.
  - `seconds` > 59 becomes 59.
  - Clamped values are 7 bits (minute) and 6 bits (seconds, zero-extended to 7).
- Converter FSM states: CONV_IDLE, CONV_SHIFT, CONV_DONE.
- CONV_IDLE:
  - If the clamped `{minute, seconds}` differs from the last committed pair, capture it into shift registers.
  - Go to CONV_SHIFT and set `busy`.
- CONV_SHIFT:
  - Seven iterations; minute and seconds are converted in parallel.
  - Each iteration adds 3 to every BCD nibble ≥5, then shifts left 1.
  - After the 7th iteration go to CONV_DONE.
- CONV_DONE:
  - Write results to `bcd`.
  - Record the captured pair as last committed.
  - Clear `busy` and go to CONV_IDLE.
- Inputs that change during CONV_SHIFT/CONV_DONE are ignored for that conversion. They are re-compared in CONV_IDLE on the next cycle, so the latest value always wins.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - `an` has exactly one bit low, at the current index.
  - `seg` shows the `bcd` nibble for that index.
  - `seg` patterns, hex, digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
- Colon, meaningful only while index = 2; otherwise `dp` = 1:
  - RUNNING: `dp` = 0 (lit).
  - PAUSED: `dp` = blink phase (0 lit, 1 dark); the phase toggles every BLINK_DIV cycles.
  - IDLE/11: `dp` = 1.
  - The blink counter and phase reset to 0 whenever `state` is not PAUSED, so each pause starts lit.

## Timing
- Reset values:
  - `an` = 4'b1111, `seg` = 7'h7F, `dp` = 1, `bcd` = 16'h0000, `busy` = 0.
  - FSM in CONV_IDLE, last committed pair = 0/0.
  - Refresh counter 0, digit index 0, blink counter 0, blink phase 0.
- First enabled digit is index 0, asserted on the first rising edge after reset release.
- `an`, `seg` and `dp` are registered and change together; all three update on the same edge as the digit index.
- Conversion latency:
  - Capture at edge E; `busy` = 1 from E.
  - Shifts on E+1..E+7.
  - `bcd` valid and `busy` = 0 at E+8.
  - A new value present before E is committed within 9 edges of first being presented while idle.
- Back-to-back conversions: at most one idle cycle between CONV_DONE and the next capture.
- Unchanged inputs cause no conversion; `busy` stays 0.
- Reset mid-conversion: aborts immediately; `bcd` = 0 and `busy` = 0 asynchronously.
- Scan wraps from index 3 to 0 with no blank cycle.
- An edge where `bcd` commits and the scan advances together uses the new `bcd`.

## Test plan
- Reset with `minute` = 0, `seconds` = 0, REFRESH_DIV = 4:
  - Outputs match reset values during reset.
  - After release, `an` scans E, D, B, 7, 4 cycles each.
  - `seg` = 40 on every digit; `busy` never rises.
- Present `minute` = 12, `seconds` = 34 (REFRESH_DIV = 4, `state` = 01):
  - `busy` is high for 8 cycles.
  - `bcd` = 16'h1234 at E+8.
  - While `an` = B: `seg` = 24 and `dp` = 0; `dp` = 1 on the other digits.
- Clamp: `minute` = 200, `seconds` = 63 → `bcd` = 16'h9959.
- Mid-conversion change: 05:07 then 05:08 two cycles after capture.
  - `bcd` = 0507 first.
  - Then a second conversion, ending in `bcd` = 0508.
- Colon, BLINK_DIV = 8:
  - `state` = 10: on digit 2, `dp` is lit for 8 cycles, dark for 8, repeating.
  - `state` = 00: `dp` stays 1.
  - 10→01→10: blink restarts lit.
- Reset asserted at E+4 of the 59:59 conversion:
  - `bcd` = 0 and `busy` = 0 immediately.
  - After release with inputs unchanged, a fresh conversion yields 16'h5959.
